word_guess_ctrl: RTL and testbench

//  Game controller for the word-guessing lab. It holds a WORD_LEN-letter secret word and accepts one
//  7-bit ASCII guess at a time. It sequences a per-letter compare across every word position, one

---
 rtl/word_guess_ctrl.sv | 143 ++++++++++++++
 tb/tb_word_guess_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_guess_ctrl.sv
// Word-guessing game controller: latches a secret word and scans each guess
// across all letter positions, one per clock, tracking reveals, misses and the outcome.
module word_guess_ctrl #(
    parameter int WORD_LEN  = 5,
    parameter int MAX_WRONG = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_load,
    input  logic [7*WORD_LEN-1:0] word_flat,
    input  logic                  guess_valid,
    input  logic [6:0]            guess_ascii,
    output logic                  guess_ready,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  result_hit,
    output logic [WORD_LEN-1:0]   revealed_mask,
    output logic [3:0]            wrong_count,
    output logic                  game_won,
    output logic                  game_lost
);
    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_SCAN,
        S_DONE,
        S_WON,
        S_LOST
    } state_t;

    state_t                state_reg, state_next;
    logic [7*WORD_LEN-1:0] word_reg, word_next;
    logic [6:0]            guess_reg, guess_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  hit_reg, hit_next;
    logic [WORD_LEN-1:0]   mask_reg, mask_next;
    logic [3:0]            count_reg, count_next;
    logic [3:0]            count_upd;
    logic [WORD_LEN-1:0]   match_vec;

    // Every position is compared in parallel; the scan just walks idx over the results.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_LEN; gi++) begin : g_match
            assign match_vec[gi] = (word_reg[7*gi +: 7] == guess_reg);
        end
    endgenerate

    always_comb begin
        count_upd = count_reg;
        if (!hit_reg && (count_reg < 4'(MAX_WRONG))) begin
            count_upd = count_reg + 4'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        guess_next = guess_reg;
        idx_next   = idx_reg;
        hit_next   = hit_reg;
        mask_next  = mask_reg;
        count_next = count_reg;

        case (state_reg)
            S_IDLE: begin
            end
            S_READY: begin
                if (guess_valid) begin
                    guess_next = guess_ascii;
                    idx_next   = '0;
                    hit_next   = 1'b0;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (match_vec[idx_reg]) begin
                    mask_next[idx_reg] = 1'b1;
                    hit_next           = 1'b1;
                end
                if (idx_reg == IDX_W'(WORD_LEN - 1)) begin
                    state_next = S_DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_DONE: begin
                count_next = count_upd;
                if (&mask_reg) begin
                    state_next = S_WON;
                end else if (count_upd == 4'(MAX_WRONG)) begin
                    state_next = S_LOST;
                end else begin
                    state_next = S_READY;
                end
            end
            S_WON, S_LOST: begin
            end
            default: state_next = S_IDLE;
        endcase

        // A new word overrides whatever the game was doing, including a scan in flight.
        if (word_load) begin
            word_next  = word_flat;
            mask_next  = '0;
            count_next = '0;
            idx_next   = '0;
            hit_next   = 1'b0;
            state_next = S_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            word_reg  <= '0;
            guess_reg <= '0;
            idx_reg   <= '0;
            hit_reg   <= 1'b0;
            mask_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            guess_reg <= guess_next;
            idx_reg   <= idx_next;
            hit_reg   <= hit_next;
            mask_reg  <= mask_next;
            count_reg <= count_next;
        end
    end

    assign guess_ready   = (state_reg == S_READY);
    assign busy          = (state_reg == S_SCAN) || (state_reg == S_DONE);
    assign result_valid  = (state_reg == S_DONE);
    assign result_hit    = (state_reg == S_DONE) && hit_reg;
    assign revealed_mask = mask_reg;
    assign wrong_count   = count_reg;
    assign game_won      = (state_reg == S_WON);
    assign game_lost     = (state_reg == S_LOST);
endmodule

// File: tb/tb_word_guess_ctrl.sv
// Scoreboard bench for word_guess_ctrl: a game-level model predicts each guess outcome,
// and a monitor checks every result pulse against the queued predictions.
module tb_word_guess_ctrl;
    localparam int WL = 5;
    localparam int MW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            word_load = 1'b0;
    logic [7*WL-1:0] word_flat = '0;
    logic            guess_valid = 1'b0;
    logic [6:0]      guess_ascii = '0;
    logic            guess_ready, busy, result_valid, result_hit;
    logic [WL-1:0]   revealed_mask;
    logic [3:0]      wrong_count;
    logic            game_won, game_lost;

    word_guess_ctrl #(.WORD_LEN(WL), .MAX_WRONG(MW)) dut (
        .clk(clk), .rst(rst), .word_load(word_load), .word_flat(word_flat),
        .guess_valid(guess_valid), .guess_ascii(guess_ascii),
        .guess_ready(guess_ready), .busy(busy), .result_valid(result_valid),
        .result_hit(result_hit), .revealed_mask(revealed_mask),
        .wrong_count(wrong_count), .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        logic [WL-1:0] mask;
        int          count;
        bit          won;
        bit          lost;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t pe;
    bit   pend = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Game model: 0 = no word, 1 = playing, 2 = won, 3 = lost
    logic [6:0]    m_word [WL];
    logic [WL-1:0] m_mask;
    int            m_count;
    int            m_state = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend) begin
                pend = 1'b0;
                chk("post_count", int'(wrong_count), pe.count);
                chk("post_won", int'(game_won), int'(pe.won));
                chk("post_lost", int'(game_lost), int'(pe.lost));
                chk("post_ready", int'(guess_ready), int'(!(pe.won || pe.lost)));
            end
            if (result_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result_hit", int'(result_hit), int'(e.hit));
                    chk("result_mask", int'(revealed_mask), int'(e.mask));
                    chk("result_latency", cyc - e.acc, WL);
                    $display("result: hit=%0d mask=%b latency=%0d", result_hit, revealed_mask, cyc - e.acc);
                    pe = e;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, int'(guess_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rvalid"}, int'(result_valid), 0);
        chk({tag, "_rhit"}, int'(result_hit), 0);
        chk({tag, "_mask"}, int'(revealed_mask), 0);
        chk({tag, "_count"}, int'(wrong_count), 0);
        chk({tag, "_won"}, int'(game_won), 0);
        chk({tag, "_lost"}, int'(game_lost), 0);
    endtask

    task automatic settle();
        int n = 0;
        while ((q.size() != 0 || pend) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || pend) chk("settle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic load_word(input string s);
        byte b;
        settle();
        for (int i = 0; i < WL; i++) begin
            b = s[i];
            word_flat[7*i +: 7] = b[6:0];
            m_word[i] = b[6:0];
        end
        word_load = 1'b1;
        @(negedge clk);
        word_load = 1'b0;
        m_mask = '0;
        m_count = 0;
        m_state = 1;
        $display("load: word=%s", s);
        chk("load_ready", int'(guess_ready), 1);
        chk("load_mask", int'(revealed_mask), 0);
        chk("load_count", int'(wrong_count), 0);
    endtask

    task automatic do_guess(input logic [6:0] ch);
        exp_t e;
        bit   h;
        int   n;
        settle();
        if (m_state != 1) begin
            // No word or game over: the guess must be ignored entirely.
            chk("ignored_ready", int'(guess_ready), 0);
            guess_ascii = ch;
            guess_valid = 1'b1;
            repeat (WL + 3) @(negedge clk);
            guess_valid = 1'b0;
            chk("ignored_mask", int'(revealed_mask), int'(m_mask));
            chk("ignored_count", int'(wrong_count), m_count);
            chk("ignored_won", int'(game_won), int'(m_state == 2));
            chk("ignored_lost", int'(game_lost), int'(m_state == 3));
            $display("guess: ch=%h ignored (state %0d)", ch, m_state);
            return;
        end
        n = 0;
        while (!guess_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!guess_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        h = 1'b0;
        for (int i = 0; i < WL; i++) begin
            if (m_word[i] == ch) begin
                h = 1'b1;
                m_mask[i] = 1'b1;
            end
        end
        if (!h && m_count < MW) m_count++;
        e.hit = h;
        e.mask = m_mask;
        e.count = m_count;
        e.won = (m_mask == {WL{1'b1}});
        e.lost = !e.won && (m_count == MW);
        e.acc = cyc + 1;
        m_state = e.won ? 2 : (e.lost ? 3 : 1);
        q.push_back(e);
        guess_ascii = ch;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        $display("guess: ch=%h expect hit=%0d mask=%b count=%0d", ch, e.hit, e.mask, e.count);
    endtask

    task automatic abort_scan(input bit use_rst, input string s);
        byte b;
        settle();
        chk("abort_pre_ready", int'(guess_ready), 1);
        guess_ascii = 7'h63;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 1);
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            for (int i = 0; i < WL; i++) begin
                b = s[i];
                word_flat[7*i +: 7] = b[6:0];
                m_word[i] = b[6:0];
            end
            word_load = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        word_load = 1'b0;
        m_mask = '0;
        m_count = 0;
        if (use_rst) begin
            m_state = 0;
            check_all_zero("rst_abort");
        end else begin
            m_state = 1;
            chk("load_abort_ready", int'(guess_ready), 1);
            chk("load_abort_busy", int'(busy), 0);
            chk("load_abort_mask", int'(revealed_mask), 0);
            chk("load_abort_count", int'(wrong_count), 0);
        end
        $display("abort: by %s", use_rst ? "rst" : "word_load");
        repeat (WL + 2) @(negedge clk);
    endtask

    initial begin : stim
        string s;
        byte   b;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            guess_valid = 1'($urandom_range(0, 1));
            guess_ascii = 7'($urandom);
            @(negedge clk);
            check_all_zero("idle");
        end
        guess_valid = 1'b0;

        load_word("crack");
        do_guess(7'h63);
        do_guess(7'h7A);
        do_guess(7'h63);
        do_guess(7'h72);
        do_guess(7'h61);
        do_guess(7'h6B);
        do_guess(7'h71);

        load_word("crack");
        do_guess(7'h62);
        do_guess(7'h64);
        do_guess(7'h65);
        do_guess(7'h66);
        do_guess(7'h67);
        do_guess(7'h68);
        do_guess(7'h63);

        load_word("crack");
        abort_scan(1'b0, "sword");
        do_guess(7'h77);
        abort_scan(1'b1, "");
        do_guess(7'h73);

        for (int g = 0; g < 6; g++) begin
            s = "aaaaa";
            for (int i = 0; i < WL; i++) begin
                b = byte'(8'h61 + $urandom_range(0, 5));
                s[i] = b;
            end
            load_word(s);
            for (int k = 0; k < 40 && m_state == 1; k++) begin
                do_guess(7'(8'h61 + $urandom_range(0, 7)));
            end
            do_guess(7'(8'h61 + $urandom_range(0, 7)));
        end

        settle();
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
